// File: rtl/axistream_packet_snooper_if.sv
// AXI Stream link bundle: source, sink and passive-monitor views of one stream.
interface axistream_packet_snooper_if #(
    parameter int DATA_WIDTH = 64
) ();
    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] TDATA;
    logic [BYTES-1:0]      TKEEP;
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;

    modport master  (output TDATA, TKEEP, TVALID, TLAST, input  TREADY);
    modport slave   (input  TDATA, TKEEP, TVALID, TLAST, output TREADY);
    modport monitor (input  TDATA, TKEEP, TVALID, TREADY, TLAST);
endinterface

// File: rtl/axistream_packet_snooper.sv
// Passive AXIS snooper copying whole packets into packet memory, reporting byte length and drops.
// Zero latency: writes, done and abort are combinational from the current beat; never drives TREADY.
module axistream_packet_snooper #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 9,
    parameter bit PESSIMISTIC   = 1'b0,
    parameter bit TRUNCATE      = 1'b1,
    parameter bit SYNC_ON_RESET = 1'b1,
    parameter int CNT_WIDTH     = 32,
    localparam int BYTES        = DATA_WIDTH / 8,
    localparam int LEN_W        = ADDR_WIDTH + $clog2(BYTES) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    axistream_packet_snooper_if.monitor      s_axis,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic [DATA_WIDTH-1:0]            wr_data,
    output logic [BYTES-1:0]                 wr_strb,
    output logic                             wr_en,
    input  logic                             mem_ready,
    output logic                             done,
    output logic [LEN_W-1:0]                 byte_len,
    output logic                             truncated,
    output logic                             abort,
    output logic [CNT_WIDTH-1:0]             drop_cnt
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {S_SYNC, S_START, S_COPY, S_TRUNC, S_DROP} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  mr_q;
    logic                  rdy, beat, cnt_inc;
    logic                  wr_en_c, done_c, abort_c, trunc_c;
    logic [LEN_W-1:0]      len_c, keep_bytes;

    assign beat = s_axis.TVALID && s_axis.TREADY;
    assign rdy  = PESSIMISTIC ? mr_q : mem_ready;

    // TKEEP is contiguous, so its population count is the valid byte count.
    always_comb begin
        keep_bytes = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep_bytes = keep_bytes + LEN_W'(s_axis.TKEEP[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_inc = 1'b0;
        wr_en_c = 1'b0;
        done_c  = 1'b0;
        abort_c = 1'b0;
        trunc_c = 1'b0;
        len_c   = '0;
        if (beat) begin
            case (state_q)
                S_SYNC: if (s_axis.TLAST) state_d = S_START;
                S_START: begin
                    if (rdy) begin
                        wr_en_c = 1'b1;
                        if (s_axis.TLAST) begin
                            done_c = 1'b1;
                            len_c  = keep_bytes;
                        end else begin
                            addr_d  = ADDR_WIDTH'(1);
                            state_d = S_COPY;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                        if (!s_axis.TLAST) state_d = S_DROP;
                    end
                end
                S_COPY: begin
                    if (!rdy) begin
                        abort_c = 1'b1;
                        cnt_inc = 1'b1;
                        addr_d  = '0;
                        state_d = s_axis.TLAST ? S_START : S_DROP;
                    end else if (s_axis.TLAST) begin
                        wr_en_c = 1'b1;
                        done_c  = 1'b1;
                        len_c   = LEN_W'(addr_q) * LEN_W'(BYTES) + keep_bytes;
                        addr_d  = '0;
                        state_d = S_START;
                    end else if (addr_q != LAST_ADDR) begin
                        wr_en_c = 1'b1;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                    end else if (TRUNCATE) begin
                        wr_en_c = 1'b1;
                        addr_d  = '0;
                        state_d = S_TRUNC;
                    end else begin
                        abort_c = 1'b1;
                        cnt_inc = 1'b1;
                        addr_d  = '0;
                        state_d = S_DROP;
                    end
                end
                S_TRUNC: begin
                    if (s_axis.TLAST) begin
                        done_c  = 1'b1;
                        trunc_c = 1'b1;
                        len_c   = LEN_W'(DEPTH * BYTES);
                        state_d = S_START;
                    end
                end
                S_DROP:  if (s_axis.TLAST) state_d = S_START;
                default: state_d = S_SYNC;
            endcase
        end
        cnt_d = (cnt_inc && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    // Reset gates the strobes in the same cycle; the memory treats reset as an abort.
    assign wr_en     = wr_en_c && !rst;
    assign done      = done_c  && !rst;
    assign abort     = abort_c && !rst;
    assign truncated = trunc_c && !rst;
    assign wr_addr   = rst ? '0 : addr_q;
    assign drop_cnt  = rst ? '0 : cnt_q;
    assign byte_len  = len_c;
    assign wr_data   = s_axis.TDATA;
    assign wr_strb   = s_axis.TKEEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC_ON_RESET ? S_SYNC : S_START;
            addr_q  <= '0;
            cnt_q   <= '0;
            mr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            mr_q    <= mem_ready && !done_c;
        end
    end
endmodule

// File: tb/tb_axistream_packet_snooper.sv
// Four snooper configurations watch one shared stream; a packet-level model predicts every cycle.
module tb_axistream_packet_snooper;
    localparam int N = 4;
    localparam int DEPTH = 4;
    localparam int BYTES = 8;
    localparam logic [N-1:0] PESS_V  = 4'b0100;
    localparam logic [N-1:0] TRUNC_V = 4'b1101;
    localparam logic [N-1:0] SYNC_V  = 4'b0111;
    localparam int F_OK = 0, F_DROP = 1, F_TRUNC = 2;

    logic clk = 1'b0;
    logic rst, mem_ready;
    axistream_packet_snooper_if #(.DATA_WIDTH(64)) axis ();

    logic        wr_en [N];
    logic        done [N];
    logic        abort [N];
    logic        truncated [N];
    logic [1:0]  wr_addr [N];
    logic [63:0] wr_data [N];
    logic [7:0]  wr_strb [N];
    logic [5:0]  byte_len [N];
    logic [3:0]  drop_cnt [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        axistream_packet_snooper #(
            .DATA_WIDTH(64), .ADDR_WIDTH(2), .PESSIMISTIC(PESS_V[g]),
            .TRUNCATE(TRUNC_V[g]), .SYNC_ON_RESET(SYNC_V[g]), .CNT_WIDTH(4)
        ) u_dut (
            .clk(clk), .rst(rst), .s_axis(axis),
            .wr_addr(wr_addr[g]), .wr_data(wr_data[g]), .wr_strb(wr_strb[g]),
            .wr_en(wr_en[g]), .mem_ready(mem_ready), .done(done[g]),
            .byte_len(byte_len[g]), .truncated(truncated[g]), .abort(abort[g]),
            .drop_cnt(drop_cnt[g])
        );
    end

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit synced [N];
    int idx [N], fate [N], drops [N];
    bit prev_mr [N], prev_done [N];
    int n_wr [N], n_done [N], n_abort [N], last_len [N];
    bit last_trunc [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            n_wr[i] = 0; n_done[i] = 0; n_abort[i] = 0; last_len[i] = 0; last_trunc[i] = 0;
        end
    endtask

    // Packet-level view: each packet has a fate decided on its first beat and refined later.
    task automatic model_check(input int i);
        bit beat, rdy, lst, e_wr, e_done, e_abort, e_trunc;
        int e_len, e_addr, old_drops;
        e_wr = 0; e_done = 0; e_abort = 0; e_trunc = 0; e_len = 0; e_addr = 0;
        old_drops = drops[i];
        lst  = axis.TLAST;
        beat = axis.TVALID && axis.TREADY;
        if (rst) begin
            check($sformatf("i%0d rst_wr_en", i), wr_en[i], 0);
            check($sformatf("i%0d rst_done", i), done[i], 0);
            check($sformatf("i%0d rst_abort", i), abort[i], 0);
            check($sformatf("i%0d rst_wr_addr", i), wr_addr[i], 0);
            check($sformatf("i%0d rst_truncated", i), truncated[i], 0);
            check($sformatf("i%0d rst_drop_cnt", i), drop_cnt[i], 0);
            synced[i] = !SYNC_V[i]; idx[i] = 0; fate[i] = F_OK; drops[i] = 0;
            prev_mr[i] = 0; prev_done[i] = 0;
            return;
        end
        rdy = PESS_V[i] ? (prev_mr[i] && !prev_done[i]) : mem_ready;
        if (beat) begin
            if (!synced[i]) begin
                if (lst) synced[i] = 1;
            end else if (idx[i] == 0) begin
                if (rdy) begin
                    e_wr = 1;
                    if (lst) begin
                        e_done = 1; e_len = $countones(axis.TKEEP);
                    end else begin
                        fate[i] = F_OK; idx[i] = 1;
                    end
                end else begin
                    drops[i]++;
                    if (!lst) begin fate[i] = F_DROP; idx[i] = 1; end
                end
            end else begin
                e_addr = idx[i];
                case (fate[i])
                    F_OK: begin
                        if (!rdy) begin
                            e_abort = 1; drops[i]++; fate[i] = F_DROP;
                        end else if (lst) begin
                            e_wr = 1; e_done = 1; e_len = idx[i] * BYTES + $countones(axis.TKEEP);
                        end else if (idx[i] < DEPTH - 1) begin
                            e_wr = 1;
                        end else if (TRUNC_V[i]) begin
                            e_wr = 1; fate[i] = F_TRUNC;
                        end else begin
                            e_abort = 1; drops[i]++; fate[i] = F_DROP;
                        end
                    end
                    F_TRUNC: if (lst) begin e_done = 1; e_trunc = 1; e_len = DEPTH * BYTES; end
                    default: ;
                endcase
                idx[i] = lst ? 0 : idx[i] + 1;
            end
        end
        check($sformatf("i%0d wr_en", i), wr_en[i], e_wr);
        check($sformatf("i%0d done", i), done[i], e_done);
        check($sformatf("i%0d abort", i), abort[i], e_abort);
        check($sformatf("i%0d drop_cnt", i), drop_cnt[i], (old_drops > 15) ? 15 : old_drops);
        if (e_wr) begin
            check($sformatf("i%0d wr_addr", i), wr_addr[i], e_addr);
            check($sformatf("i%0d wr_data", i), wr_data[i], axis.TDATA);
            check($sformatf("i%0d wr_strb", i), wr_strb[i], axis.TKEEP);
        end
        if (e_done) begin
            check($sformatf("i%0d byte_len", i), byte_len[i], e_len);
            check($sformatf("i%0d truncated", i), truncated[i], e_trunc);
        end
        prev_mr[i] = mem_ready; prev_done[i] = e_done;
        if (wr_en[i]) n_wr[i]++;
        if (abort[i]) n_abort[i]++;
        if (done[i]) begin
            n_done[i]++; last_len[i] = byte_len[i]; last_trunc[i] = truncated[i];
        end
    endtask

    task automatic step(input logic v, input logic r, input logic l, input logic [7:0] k,
                        input logic mr, input logic rs);
        rst = rs; mem_ready = mr;
        axis.TVALID = v; axis.TREADY = r; axis.TLAST = l; axis.TKEEP = k;
        axis.TDATA = {$urandom, $urandom};
        @(negedge clk);
        for (int i = 0; i < N; i++) model_check(i);
        @(posedge clk);
        #1;
    endtask

    task automatic pkt(input int n, input logic [7:0] lk, input int mr_low_from, input bit idle);
        for (int b = 0; b < n; b++)
            step(1'b1, 1'b1, b == n - 1, (b == n - 1) ? lk : 8'hFF, b < mr_low_from, 1'b0);
        if (idle) step(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    endtask

    initial begin
        axis.TVALID = 0; axis.TREADY = 0; axis.TLAST = 0; axis.TKEEP = '0; axis.TDATA = '0;
        rst = 1; mem_ready = 0;
        clear_stats();
        @(posedge clk); #1;
        step(0, 0, 0, 8'h00, 0, 1);
        step(1, 1, 1, 8'hFF, 1, 1);

        // First packet after reset only resynchronises; the next one is copied.
        pkt(3, 8'hFF, 99, 1);
        check("sync_no_writes", n_wr[0], 0);
        check("nosync_writes", n_wr[3], 3);
        clear_stats();
        pkt(3, 8'h0F, 99, 1);
        check("pkt3_writes", n_wr[0], 3);
        check("pkt3_done", n_done[0], 1);
        check("pkt3_len", last_len[0], 20);

        // Memory not ready on the first beat drops the packet.
        clear_stats();
        pkt(4, 8'hFF, 0, 1);
        check("drop_no_writes", n_wr[0], 0);
        check("drop_cnt_1", drop_cnt[0], 1);
        pkt(2, 8'h03, 99, 1);
        check("after_drop_writes", n_wr[0], 2);

        // Memory drops ready mid-packet.
        clear_stats();
        pkt(5, 8'hFF, 1, 1);
        check("abort_once", n_abort[0], 1);
        check("abort_writes", n_wr[0], 1);
        check("abort_drop_cnt", drop_cnt[0], 2);
        pkt(1, 8'h01, 99, 1);

        // Oversized packet: truncation versus abort.
        clear_stats();
        pkt(6, 8'hFF, 99, 1);
        check("trunc_writes", n_wr[0], 4);
        check("trunc_done", n_done[0], 1);
        check("trunc_flag", last_trunc[0], 1);
        check("trunc_len", last_len[0], 32);
        check("oversize_abort", n_abort[1], 1);
        check("oversize_no_done", n_done[1], 0);

        // Pessimistic ready blocks a packet immediately following done.
        clear_stats();
        pkt(1, 8'hFF, 99, 0);
        pkt(1, 8'hFF, 99, 1);
        check("pess_writes", n_wr[2], 1);
        check("pess_done", n_done[2], 1);

        // Backpressure stalls mid-packet, then reset mid-packet.
        clear_stats();
        step(1, 1, 0, 8'hFF, 1, 0);
        step(1, 1, 0, 8'hFF, 1, 0);
        for (int c = 0; c < 3; c++) step(1, 0, 0, 8'hFF, 1, 0);
        step(1, 1, 0, 8'hFF, 1, 0);
        check("bp_writes", n_wr[0], 3);
        step(1, 1, 0, 8'hFF, 1, 1);
        check("post_rst_drop_cnt", drop_cnt[0], 0);
        clear_stats();
        pkt(2, 8'hFF, 99, 1);
        check("post_rst_sync", n_wr[0], 0);
        pkt(2, 8'hFF, 99, 1);
        check("post_rst_copy", n_wr[0], 2);

        // Randomised traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                 8'hFF >> $urandom_range(0, 7), $urandom_range(0, 19) > 2,
                 $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axistream_packet_snooper.md
# axistream_packet_snooper

Parametrised passive snooper for one AXI Stream link that copies whole packets into a packet memory and reports their length. It sits beside an AXI Stream connection, monitors `TVALID`/`TREADY` without driving the bus, and feeds the packet-filter memory write port. It adds several behaviours to the basic snooper:
- byte-accurate length from `TKEEP`;
- packet-boundary resynchronisation after reset;
- explicit abort and overflow handling;
- a dropped-packet counter.

## Interface
- `DATA_WIDTH`, 64: bus and memory word width; multiple of 8. `BYTES = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 9: memory word address width. `DEPTH = 2**ADDR_WIDTH`.
- `PESSIMISTIC`, 0: 1 = register `mem_ready` one cycle and force it low the cycle after `done`.
- `TRUNCATE`, 1: 1 = oversized packets are truncated to `DEPTH` words; 0 = oversized packets are aborted.
- `SYNC_ON_RESET`, 1: 1 = after reset, wait for a `TLAST` beat before copying; 0 = the first beat after reset starts a packet.
- `CNT_WIDTH`, 32: width of `drop_cnt`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `TDATA` in DATA_WIDTH: snooped data.
- `TKEEP` in BYTES: snooped byte enables; contiguous from bit 0.
- `TVALID` in 1: snooped.
- `TREADY` in 1: snooped; this is an input.
- `TLAST` in 1: snooped.
- `wr_addr` out ADDR_WIDTH: memory word address.
- `wr_data` out DATA_WIDTH: equal to `TDATA`.
- `wr_strb` out BYTES: equal to `TKEEP`.
- `wr_en` out 1: memory write strobe.
- `mem_ready` in 1: memory can accept a packet.
- `done` out 1: one-cycle pulse on the final write of a packet.
- `byte_len` out ADDR_WIDTH+log2(BYTES)+1: packet length in bytes; valid only while `done`=1.
- `truncated` out 1: valid with `done`; high if the packet exceeded `DEPTH` words.
- `abort` out 1: one-cycle pulse; memory discards the partial packet.
- `drop_cnt` out CNT_WIDTH: saturating count of dropped or aborted packets.

## Operation
Definitions:
- beat = `TVALID && TREADY`.
- `rdy` = `mem_ready`, or its registered version when `PESSIMISTIC`=1.

States:
- **SYNC**: no writes. A beat with `TLAST`=1 moves to START.
- **START** (packet boundary):
  - beat with `rdy`=1: write at address 0, `addr` becomes 1, go to COPY. If `TLAST`=1 on that beat, assert `done`, set `byte_len`=popcount(`TKEEP`), stay in START.
  - beat with `rdy`=0: increment `drop_cnt`, go to DROP. If `TLAST`=1, stay in START instead.
- **COPY**:
  - beat with `rdy`=1 and `addr` < DEPTH-1: write at `addr`, then `addr`+1.
  - beat with `TLAST`=1: write, assert `done`, `byte_len` = `addr`*BYTES + popcount(`TKEEP`), then `addr` ← 0 and go to START.
  - beat with `rdy`=0: no write, pulse `abort`, increment `drop_cnt`, `addr` ← 0. Go to DROP, or to START if `TLAST`=1.
  - beat at `addr` = DEPTH-1 with `TLAST`=0 and `TRUNCATE`=1: write, then go to TRUNC.
  - beat at `addr` = DEPTH-1 with `TLAST`=0 and `TRUNCATE`=0: write suppressed, `abort` pulses, `drop_cnt` increments, go to DROP.
- **TRUNC**: no writes. The `TLAST` beat asserts `done` (with `wr_en`=0), `truncated`=1, `byte_len`=DEPTH*BYTES, then goes to START.
- **DROP**: no writes. A `TLAST` beat goes to START.

Width and counter rules:
- `byte_len` is computed at full width and never wraps.
- `drop_cnt` saturates at all-ones.
- `abort` and `done` are never high together.

## Timing
- `wr_en`, `wr_addr`, `wr_data`, `wr_strb`, `done`, `byte_len`, `truncated` and `abort` are combinational from the current beat and state. Latency is zero: the write happens in the same cycle as the beat.
- `done` coincides with the `wr_en` of the last word. The TRUNC case is the only one where `done` has no `wr_en`.
- With `PESSIMISTIC`=1, `rdy` lags `mem_ready` by one cycle and is 0 in the cycle after `done`. A packet starting in that cycle is dropped.
- With `rst`=1, `wr_en`, `done` and `abort` are forced to 0 in that same cycle.
- Register values at the next edge after reset:
  - state = SYNC if `SYNC_ON_RESET`=1, otherwise START;
  - `addr` = 0, `drop_cnt` = 0, registered `mem_ready` = 0.
- Output values while in reset: `wr_addr`=0, `truncated`=0, `drop_cnt`=0.
- Reset mid-packet discards the packet. No `abort` pulse is issued; the memory treats reset as an abort.
- Beats with `TVALID`=1 and `TREADY`=0 are ignored and change no state.

## Test plan
- Reset, then a 3-beat packet with `SYNC_ON_RESET`=1 → no writes. A following 3-beat packet with last `TKEEP`=0x0F (64-bit bus) → writes at 0,1,2, `done` on beat 3, `byte_len`=20.
- `mem_ready`=0 at the first beat of a 4-beat packet → no `wr_en`, `drop_cnt`=1. The next packet, with `mem_ready`=1, is written from address 0.
- `mem_ready` falls on beat 2 of a 5-beat packet → `abort` pulses once on beat 2, `drop_cnt` increments, beats 3–5 are not written. The next packet starts at address 0.
- `ADDR_WIDTH`=2, `TRUNCATE`=1, 6-beat packet → writes at 0–3, `done` on beat 6 with `wr_en`=0, `truncated`=1, `byte_len`=32. The same case with `TRUNCATE`=0 → `abort` on beat 4, no `done`.
- `PESSIMISTIC`=1: two back-to-back 1-beat packets with `mem_ready` held at 1 → first packet written with `done`, second packet dropped, `drop_cnt`=1.
- Back-pressure (`TREADY`=0 with `TVALID`=1) for 3 cycles mid-packet, and `rst` asserted mid-packet → no extra writes or address increments. After reset, `drop_cnt`=0 and there are no writes until a `TLAST` beat has been seen.
